// File: rtl/return_address_stack_pkg.sv
// return_address_stack_pkg: shared PC width, stack depth and next-PC source encoding
package return_address_stack_pkg;
    localparam int PC_W      = 12;
    localparam int RAS_DEPTH = 8;
    typedef enum logic [1:0] {
        SEQ    = 2'b00,
        JUMP   = 2'b01,
        RET    = 2'b10,
        BRANCH = 2'b11
    } pc_src_e;
endpackage

// File: rtl/ras_storage.sv
// ras_storage: unreset register array with one sync write port and one async read port
module ras_storage #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[wr_addr] <= wr_data;
    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/return_address_stack.sv
// return_address_stack: bounded LIFO of return addresses with sticky overflow/underflow flags
module return_address_stack
    import return_address_stack_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int WIDTH = PC_W,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_out,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             stack_overflow,
    output logic             stack_underflow
);
    logic [PTR_W-1:0] top_addr, wr_addr;
    logic [WIDTH-1:0] rd_data;
    logic             we;

    assign empty    = count == '0;
    assign full     = count == (PTR_W+1)'(DEPTH);
    assign top_addr = PTR_W'(count - 1'b1);
    // push+pop on a non-empty stack overwrites the top in place
    assign wr_addr  = (pop && !empty) ? top_addr : count[PTR_W-1:0];
    assign we       = push && !flush && (pop || !full);
    assign top_out  = empty ? '0 : rd_data;

    ras_storage #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(PTR_W)) u_storage (
        .clk     (clk),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (push_data),
        .rd_addr (top_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count           <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else if (flush) begin
            count <= '0;
        end else if (push && pop) begin
            if (empty) begin
                count           <= (PTR_W+1)'(1);
                stack_underflow <= 1'b1;
            end
        end else if (push) begin
            if (full) stack_overflow <= 1'b1;
            else      count <= count + 1'b1;
        end else if (pop) begin
            if (empty) stack_underflow <= 1'b1;
            else       count <= count - 1'b1;
        end
    end
endmodule

// File: tb/tb_return_address_stack.sv
// tb_return_address_stack: table-driven directed check of the return address stack
module tb_return_address_stack;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0, pop = 1'b0, flush = 1'b0;
    logic [11:0] push_data = '0;
    logic [11:0] top_out;
    logic [3:0]  count;
    logic        empty, full, stack_overflow, stack_underflow;
    int          checks = 0, errors = 0;

    typedef struct {
        int push, pop, flush, data;
        int cnt, top, ovf, udf;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    return_address_stack dut (
        .clk             (clk),
        .rst             (rst),
        .push            (push),
        .pop             (pop),
        .flush           (flush),
        .push_data       (push_data),
        .top_out         (top_out),
        .count           (count),
        .empty           (empty),
        .full            (full),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    function automatic vec_t v(int pu, int po, int fl, int d, int c, int t, int o, int u);
        vec_t r;
        r.push = pu; r.pop = po; r.flush = fl; r.data = d;
        r.cnt = c; r.top = t; r.ovf = o; r.udf = u;
        return r;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(string tag, int c, int t, int o, int u);
        check({tag, " count"}, int'(count), c);
        check({tag, " top_out"}, int'(top_out), t);
        check({tag, " empty"}, int'(empty), int'(c == 0));
        check({tag, " full"}, int'(full), int'(c == 8));
        check({tag, " overflow"}, int'(stack_overflow), o);
        check({tag, " underflow"}, int'(stack_underflow), u);
    endtask

    task automatic drive(int pu, int po, int fl, int d);
        @(negedge clk);
        push = pu[0]; pop = po[0]; flush = fl[0]; push_data = 12'(d);
        #1;
    endtask

    initial begin
        // push three, pop three
        tbl.push_back(v(1,0,0,'h101, 0,'h000, 0,0));
        tbl.push_back(v(1,0,0,'h2A5, 1,'h101, 0,0));
        tbl.push_back(v(1,0,0,'h3FF, 2,'h2A5, 0,0));
        tbl.push_back(v(0,1,0,0,     3,'h3FF, 0,0));
        tbl.push_back(v(0,1,0,0,     2,'h2A5, 0,0));
        tbl.push_back(v(0,1,0,0,     1,'h101, 0,0));
        tbl.push_back(v(0,0,0,0,     0,'h000, 0,0));
        // fill to DEPTH, overflow push, drain
        for (int i = 0; i < 8; i++)
            tbl.push_back(v(1,0,0,'h010 + i, i, i == 0 ? 0 : 'h010 + i - 1, 0,0));
        tbl.push_back(v(1,0,0,'hBAD, 8,'h017, 0,0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(v(0,1,0,0, 8 - k, 'h017 - k, 1,0));
        tbl.push_back(v(0,0,0,0, 0,'h000, 1,0));
        // underflow stays sticky through push and flush
        tbl.push_back(v(0,1,0,0,     0,'h000, 1,0));
        tbl.push_back(v(1,0,0,'h0AA, 0,'h000, 1,1));
        tbl.push_back(v(0,0,1,0,     1,'h0AA, 1,1));
        tbl.push_back(v(0,0,0,0,     0,'h000, 1,1));
        // replace top
        tbl.push_back(v(1,0,0,'h044, 0,'h000, 1,1));
        tbl.push_back(v(1,0,0,'h055, 1,'h044, 1,1));
        tbl.push_back(v(1,1,0,'h0C3, 2,'h055, 1,1));
        tbl.push_back(v(0,1,0,0,     2,'h0C3, 1,1));
        tbl.push_back(v(0,1,0,0,     1,'h044, 1,1));
        tbl.push_back(v(0,0,0,0,     0,'h000, 1,1));
        // flush beats a simultaneous push
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(1,0,0,'h301 + i, i, i == 0 ? 0 : 'h300 + i, 1,1));
        tbl.push_back(v(1,0,1,'h777, 5,'h305, 1,1));
        tbl.push_back(v(1,0,0,'h123, 0,'h000, 1,1));
        tbl.push_back(v(0,0,0,0,     1,'h123, 1,1));

        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        foreach (tbl[i]) begin
            drive(tbl[i].push, tbl[i].pop, tbl[i].flush, tbl[i].data);
            check_state($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].top, tbl[i].ovf, tbl[i].udf);
        end

        // only reset clears the sticky flags
        @(negedge clk);
        push = 1'b0; pop = 1'b0; flush = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_state("rst clears flags", 0, 0, 0, 0);

        // push+pop on empty acts as a push and flags underflow
        drive(1, 1, 0, 'h5A5);
        drive(0, 0, 0, 0);
        check_state("pushpop empty", 1, 'h5A5, 0, 1);

        // push+pop while full replaces top without overflow
        for (int i = 0; i < 7; i++) drive(1, 0, 0, 'h600 + i);
        drive(1, 1, 0, 'hEEE);
        check_state("pushpop full pre", 8, 'h606, 0, 1);
        drive(0, 0, 0, 0);
        check_state("pushpop full", 8, 'hEEE, 0, 1);
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        check_state("below top kept", 7, 'h605, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
